ebus_master: RTL and testbench

Parametrised EBOX-side EBUS transaction sequencer and N-source data multiplexer. It accepts one I/O request at a time from the EBOX (CONO, CONI, DATAO, DATAI, PI-served, PI-address-in) and drives controller select, function and demand onto the EBUS. It runs the ack/xfer handshake with a timeout, returns read data and flags bus contention among the NDEV one-hot device drivers. It generalises the single fixed one-hot EBUS data mux to a configurable driver count, a timed handshake and contention detection.

---
 rtl/ebus_master.sv | 195 +++++++++++++++++++
 tb/tb_ebus_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebus_master.sv
// ebus_master: EBOX-side EBUS transaction sequencer. It runs one request at a time through
// a timed ack/xfer handshake, muxes NDEV device drivers and flags bus contention.
module ebus_master #(
  parameter int NDEV    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  CROBAR,
  input  logic                  req,
  input  logic [2:0]            reqFunc,
  input  logic [6:0]            reqCS,
  input  logic [0:35]           reqData,
  output logic                  busy,
  output logic                  done,
  output logic                  timedOut,
  output logic [0:35]           rdData,
  output logic                  contention,
  input  logic [NDEV-1:0][0:35] devData,
  input  logic [NDEV-1:0]       devDriving,
  output logic [0:35]           ebusData,
  output logic [6:0]            ebusCS,
  output logic [2:0]            ebusFunc,
  output logic                  ebusDemand,
  input  logic                  ebusAck,
  input  logic                  ebusXfer
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_DEMAND = 3'd2,
    ST_XFER   = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [9:0]  timer_r;
  logic [2:0]  func_r;
  logic [6:0]  cs_r;
  logic [0:35] wdata_r;
  logic [0:35] rd_r;
  logic        busy_r, done_r, timed_out_r, demand_r, contention_r;
  logic        accept_s, abort_s, capture_s, wr_s, master_drv_s, active_s;
  logic [6:0]  nsrc_s;
  logic [0:35] dev_or_s;

  // CONO, DATAO and PIserved are writes; everything else, reserved codes included, reads
  function automatic logic is_write(input logic [2:0] f);
    logic w;
    case (f)
      3'b000, 3'b010, 3'b100: w = 1'b1;
      default:                w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic [6:0] count_ones(input logic [NDEV-1:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < NDEV; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

  assign accept_s     = (state_r == ST_IDLE) && req;
  assign wr_s         = is_write(func_r);
  assign master_drv_s = wr_s && ((state_r == ST_SETUP) || (state_r == ST_DEMAND) ||
                                 (state_r == ST_XFER));
  assign active_s     = (state_r == ST_SETUP) || (state_r == ST_DEMAND) ||
                        (state_r == ST_XFER)  || (state_r == ST_HOLD);
  assign nsrc_s       = count_ones(devDriving) + {6'd0, master_drv_s};

  // OR of every enabled device word
  always_comb begin
    dev_or_s = '0;
    for (int i = 0; i < NDEV; i++) begin
      dev_or_s = dev_or_s | (devData[i] & {36{devDriving[i]}});
    end
  end

  assign ebusData = dev_or_s | (master_drv_s ? wdata_r : 36'd0);

  // Next-state logic; ack and xfer win over a timeout that lands on the same edge
  always_comb begin
    state_s   = state_r;
    abort_s   = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: state_s = ST_DEMAND;
      ST_DEMAND: begin
        if (ebusAck) begin
          state_s = ST_XFER;
        end else if (timer_r == TMO_LAST) begin
          state_s = ST_DONE;
          abort_s = 1'b1;
        end else begin
          state_s = ST_DEMAND;
        end
      end
      ST_XFER: begin
        if (ebusXfer) begin
          state_s   = ST_HOLD;
          capture_s = !wr_s;
        end else if (timer_r == TMO_LAST) begin
          state_s = ST_DONE;
          abort_s = 1'b1;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_HOLD: state_s = ST_DONE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; the timer restarts on every state change
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_r <= ST_IDLE;
      timer_r <= 10'd0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) begin
        timer_r <= 10'd0;
      end else if ((state_r == ST_DEMAND) || (state_r == ST_XFER)) begin
        timer_r <= timer_r + 10'd1;
      end else begin
        timer_r <= timer_r;
      end
    end
  end

  // Request latch; select and function drop back to zero on entry to DONE
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      func_r  <= 3'd0;
      cs_r    <= 7'd0;
      wdata_r <= 36'd0;
    end else if (accept_s) begin
      func_r  <= reqFunc;
      cs_r    <= reqCS;
      wdata_r <= reqData;
    end else if (state_s == ST_DONE) begin
      func_r  <= 3'd0;
      cs_r    <= 7'd0;
    end
  end

  // Registered status, handshake, read data and sticky contention
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      timed_out_r  <= 1'b0;
      demand_r     <= 1'b0;
      rd_r         <= 36'd0;
      contention_r <= 1'b0;
    end else begin
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
      timed_out_r <= abort_s;
      demand_r    <= (state_s == ST_DEMAND) || (state_s == ST_XFER);
      if (capture_s) begin
        rd_r <= ebusData;
      end
      if (accept_s) begin
        contention_r <= 1'b0;
      end else if (active_s && (nsrc_s >= 7'd2)) begin
        contention_r <= 1'b1;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign timedOut   = timed_out_r;
  assign rdData     = rd_r;
  assign contention = contention_r;
  assign ebusCS     = cs_r;
  assign ebusFunc   = func_r;
  assign ebusDemand = demand_r;

endmodule

// File: tb/tb_ebus_master.sv
// Self-checking bench for ebus_master: directed table, randomized transactions against a
// timeline model, crowbar reset mid-transfer, and NDEV=1 / NDEV=32 builds.
module tb_ebus_master;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic CROBAR, req, ebusAck, ebusXfer;
  logic [2:0]  reqFunc;
  logic [6:0]  reqCS;
  logic [0:35] reqData;

  logic [7:0]        dev_drv;
  logic [7:0][0:35]  dev_data;
  logic              busy, done, timed_out, contention, ebus_demand;
  logic [0:35]       rd_data, ebus_data;
  logic [6:0]        ebus_cs;
  logic [2:0]        ebus_func;

  logic [0:0]        d1_drv;
  logic [0:0][0:35]  d1_data;
  logic              u1_busy, u1_done, u1_to, u1_cont, u1_dem;
  logic [0:35]       u1_rd, u1_bus;
  logic [6:0]        u1_cs;
  logic [2:0]        u1_func;

  logic [31:0]       d32_drv;
  logic [31:0][0:35] d32_data;
  logic              u32_busy, u32_done, u32_to, u32_cont, u32_dem;
  logic [0:35]       u32_rd, u32_bus;
  logic [6:0]        u32_cs;
  logic [2:0]        u32_func;

  ebus_master #(.NDEV(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .CROBAR(CROBAR), .req(req), .reqFunc(reqFunc), .reqCS(reqCS),
    .reqData(reqData), .busy(busy), .done(done), .timedOut(timed_out), .rdData(rd_data),
    .contention(contention), .devData(dev_data), .devDriving(dev_drv), .ebusData(ebus_data),
    .ebusCS(ebus_cs), .ebusFunc(ebus_func), .ebusDemand(ebus_demand), .ebusAck(ebusAck),
    .ebusXfer(ebusXfer));

  ebus_master #(.NDEV(1), .TIMEOUT(TMO)) u1 (
    .clk(clk), .CROBAR(CROBAR), .req(req), .reqFunc(reqFunc), .reqCS(reqCS),
    .reqData(reqData), .busy(u1_busy), .done(u1_done), .timedOut(u1_to), .rdData(u1_rd),
    .contention(u1_cont), .devData(d1_data), .devDriving(d1_drv), .ebusData(u1_bus),
    .ebusCS(u1_cs), .ebusFunc(u1_func), .ebusDemand(u1_dem), .ebusAck(ebusAck),
    .ebusXfer(ebusXfer));

  ebus_master #(.NDEV(32), .TIMEOUT(TMO)) u32 (
    .clk(clk), .CROBAR(CROBAR), .req(req), .reqFunc(reqFunc), .reqCS(reqCS),
    .reqData(reqData), .busy(u32_busy), .done(u32_done), .timedOut(u32_to), .rdData(u32_rd),
    .contention(u32_cont), .devData(d32_data), .devDriving(d32_drv), .ebusData(u32_bus),
    .ebusCS(u32_cs), .ebusFunc(u32_func), .ebusDemand(u32_dem), .ebusAck(ebusAck),
    .ebusXfer(ebusXfer));

  int          checks = 0;
  int          errors = 0;
  string       cur_tag = "init";
  int          cur_p = 0;
  logic [35:0] rd_exp = 36'd0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s p%0d: got %b expected %b", cur_tag, name, cur_p, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s p%0d: got %o expected %o", cur_tag, name, cur_p, act, exp);
    end
  endtask

  function automatic logic [35:0] dev_or_model();
    logic [35:0] r;
    r = 36'd0;
    for (int i = 0; i < 8; i++) begin
      if (dev_drv[i]) r = r | dev_data[i];
    end
    return r;
  endfunction

  // One transaction: ack raised da cycles into DEMAND, xfer dx cycles into XFER (>= TMO means
  // never). The expected timeline is pure cycle arithmetic: accept=0, SETUP=1, DEMAND from 2.
  task automatic run_txn(input logic [2:0] f, input logic [6:0] cs, input logic [35:0] d,
                         input int da, input int dx, input bit early, input bit pulse,
                         output int done_at, output bit to_seen);
    bit          wr, abort;
    int          e, last_drv;
    logic [35:0] dor, rd_new;
    wr  = (f == 3'b000) || (f == 3'b010) || (f == 3'b100);
    dor = dev_or_model();
    if (da >= TMO) begin
      abort = 1'b1; e = 2 + TMO;
    end else if (dx >= TMO) begin
      abort = 1'b1; e = 3 + da + TMO;
    end else begin
      abort = 1'b0; e = 5 + da + dx;
    end
    last_drv = abort ? e - 1 : e - 2;
    rd_new   = (!wr && !abort) ? dor : rd_exp;
    done_at  = -1;
    to_seen  = 1'b0;
    for (int p = 0; p <= e + 1; p++) begin
      @(posedge clk); #1;
      cur_p    = p;
      req      = (p == 0) || (pulse && (p == 3 || p == e));
      reqFunc  = (p == 0) ? f : ~f;
      reqCS    = (p == 0) ? cs : ~cs;
      reqData  = (p == 0) ? d : ~d;
      ebusAck  = (da < TMO) && (p == 2 + da);
      ebusXfer = (da < TMO) && (((dx < TMO) && (p == 3 + da + dx)) || (early && (p == 2 + da)));
      #1;
      chk_b("busy", busy, (p >= 1) && (p <= e));
      chk_b("done", done, p == e);
      chk_b("timedOut", timed_out, (p == e) && abort);
      chk_b("demand", ebus_demand, (p >= 2) && (p <= last_drv));
      chk_w("cs", 36'(ebus_cs), (p >= 1 && p < e) ? 36'(cs) : 36'd0);
      chk_w("func", 36'(ebus_func), (p >= 1 && p < e) ? 36'(f) : 36'd0);
      chk_w("data", ebus_data, ((wr && p >= 1 && p <= last_drv) ? d : 36'd0) | dor);
      if (done && done_at < 0) begin
        done_at = p;
        to_seen = timed_out;
      end
      if (p == 1) begin
        chk_b("contention_clr", contention, 1'b0);
        chk_w("rd_hold", rd_data, rd_exp);
      end
      if (p == e + 1) begin
        chk_b("contention", contention, ($countones(dev_drv) + int'(wr)) >= 2);
        chk_w("rdData", rd_data, rd_new);
      end
    end
    rd_exp = rd_new;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [6:0]  cs;
    logic [35:0] d;
    int          da;
    int          dx;
    bit          early;
    logic [7:0]  drv;
    logic [35:0] devw;
    int          exp_done;
    bit          exp_to;
    logic [35:0] exp_rd;
    bit          exp_cont;
  } vec_t;

  vec_t        tbl [10];
  int          done_at;
  bit          to_seen;
  logic [2:0]  rf;
  logic [6:0]  rcs;
  logic [35:0] rd;

  initial begin
    tbl[0] = '{3'b010, 7'o060, 36'o123456701234, 0, 0, 1'b1, 8'h00, 36'd0, 5, 1'b0, 36'd0, 1'b0};
    tbl[1] = '{3'b011, 7'o061, 36'd0, 0, 2, 1'b0, 8'h08, 36'o777000000777, 7, 1'b0,
               36'o777000000777, 1'b0};
    tbl[2] = '{3'b001, 7'o062, 36'd0, 8, 0, 1'b0, 8'h00, 36'd0, 10, 1'b1, 36'o777000000777, 1'b0};
    tbl[3] = '{3'b000, 7'o063, 36'o000000000042, 0, 0, 1'b0, 8'h01, 36'o1, 5, 1'b0,
               36'o777000000777, 1'b1};
    tbl[4] = '{3'b000, 7'o064, 36'o5, 0, 0, 1'b0, 8'h00, 36'd0, 5, 1'b0, 36'o777000000777, 1'b0};
    tbl[5] = '{3'b011, 7'o065, 36'd0, 1, 8, 1'b0, 8'h08, 36'o111111111111, 12, 1'b1,
               36'o777000000777, 1'b0};
    tbl[6] = '{3'b101, 7'o066, 36'd0, 2, 1, 1'b0, 8'h80, 36'o000000000123, 8, 1'b0,
               36'o000000000123, 1'b0};
    tbl[7] = '{3'b111, 7'o067, 36'd0, 0, 0, 1'b1, 8'h02, 36'o707070707070, 5, 1'b0,
               36'o707070707070, 1'b0};
    tbl[8] = '{3'b100, 7'o070, 36'o400000000001, 7, 7, 1'b0, 8'h00, 36'd0, 19, 1'b0,
               36'o707070707070, 1'b0};
    tbl[9] = '{3'b011, 7'o071, 36'd0, 0, 1, 1'b0, 8'h11, 36'o252525252525, 6, 1'b0,
               36'o252525252525, 1'b1};

    CROBAR = 1'b1; req = 1'b0; reqFunc = 3'd0; reqCS = 7'd0; reqData = 36'd0;
    ebusAck = 1'b0; ebusXfer = 1'b0;
    for (int j = 0; j < 8; j++) dev_data[j] = 36'd0;
    dev_data[2] = 36'o123123123123;
    dev_drv = 8'h04;
    d1_drv = 1'b0; d1_data[0] = 36'd0;
    d32_drv = 32'd0;
    for (int j = 0; j < 32; j++) d32_data[j] = 36'd0;

    cur_tag = "reset";
    repeat (2) @(posedge clk);
    #1;
    chk_b("busy", busy, 1'b0);
    chk_b("done", done, 1'b0);
    chk_b("timedOut", timed_out, 1'b0);
    chk_w("rdData", rd_data, 36'd0);
    chk_b("contention", contention, 1'b0);
    chk_w("cs", 36'(ebus_cs), 36'd0);
    chk_w("func", 36'(ebus_func), 36'd0);
    chk_b("demand", ebus_demand, 1'b0);
    chk_w("data", ebus_data, 36'o123123123123);
    @(posedge clk); #1;
    CROBAR = 1'b0;
    dev_drv = 8'h00;

    for (int i = 0; i < 10; i++) begin
      cur_tag = $sformatf("tbl%0d", i);
      dev_drv = tbl[i].drv;
      for (int j = 0; j < 8; j++) dev_data[j] = tbl[i].devw;
      run_txn(tbl[i].f, tbl[i].cs, tbl[i].d, tbl[i].da, tbl[i].dx, tbl[i].early,
              (i % 2) == 1, done_at, to_seen);
      chk_w("done_cycle", 36'(done_at), 36'(tbl[i].exp_done));
      chk_b("abort", to_seen, tbl[i].exp_to);
      chk_w("rd_final", rd_data, tbl[i].exp_rd);
      chk_b("cont_final", contention, tbl[i].exp_cont);
    end

    for (int n = 0; n < 30; n++) begin
      cur_tag = $sformatf("rnd%0d", n);
      rf  = 3'($urandom_range(0, 7));
      rcs = 7'($urandom());
      rd  = {4'($urandom()), $urandom()};
      for (int j = 0; j < 8; j++) dev_data[j] = {4'($urandom()), $urandom()};
      case ($urandom_range(0, 3))
        0:       dev_drv = 8'h00;
        1, 2:    dev_drv = 8'd1 << $urandom_range(0, 7);
        default: dev_drv = (8'd1 << $urandom_range(0, 3)) | (8'd16 << $urandom_range(0, 3));
      endcase
      run_txn(rf, rcs, rd, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), done_at, to_seen);
    end

    // Crowbar while a write sits in XFER
    cur_tag = "crobar";
    cur_p = 0;
    dev_drv = 8'h00;
    @(posedge clk); #1;
    req = 1'b1; reqFunc = 3'b010; reqCS = 7'o070; reqData = 36'o555555555555;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    ebusAck = 1'b1;
    @(posedge clk); #1;
    ebusAck = 1'b0;
    #1;
    chk_b("in_xfer", ebus_demand, 1'b1);
    chk_w("in_xfer_data", ebus_data, 36'o555555555555);
    dev_data[5] = 36'o000000777777;
    dev_drv = 8'h20;
    CROBAR = 1'b1;
    #1;
    chk_b("busy", busy, 1'b0);
    chk_b("done", done, 1'b0);
    chk_b("timedOut", timed_out, 1'b0);
    chk_w("rdData", rd_data, 36'd0);
    chk_b("contention", contention, 1'b0);
    chk_w("cs", 36'(ebus_cs), 36'd0);
    chk_w("func", 36'(ebus_func), 36'd0);
    chk_b("demand", ebus_demand, 1'b0);
    chk_w("data", ebus_data, 36'o000000777777);
    @(posedge clk); #1;
    CROBAR = 1'b0;
    rd_exp = 36'd0;
    cur_tag = "after_crobar";
    run_txn(3'b011, 7'o072, 36'd0, 1, 1, 1'b0, 1'b0, done_at, to_seen);
    chk_w("done_cycle", 36'(done_at), 36'd7);
    chk_w("rd_final", rd_data, 36'o000000777777);

    // Narrowest and widest builds: DATAI from the highest-index driver, req pulsed while busy
    cur_tag = "ndev";
    dev_drv = 8'h00;
    d1_data[0] = 36'o135713571357;
    d1_drv = 1'b1;
    for (int j = 0; j < 32; j++) d32_data[j] = {4'($urandom()), $urandom()};
    d32_data[31] = 36'o246024602460;
    d32_drv = 32'h8000_0000;
    run_txn(3'b011, 7'o044, 36'd0, 0, 1, 1'b0, 1'b1, done_at, to_seen);
    chk_w("u1_rd", u1_rd, 36'o135713571357);
    chk_w("u32_rd", u32_rd, 36'o246024602460);
    chk_w("u32_bus", u32_bus, 36'o246024602460);
    chk_b("u1_busy", u1_busy, 1'b0);
    chk_b("u32_busy", u32_busy, 1'b0);
    chk_b("u1_cont", u1_cont, 1'b0);
    chk_b("u32_cont", u32_cont, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
